// File: rtl/display_scan_driver_if.sv
//------------------------------------------------------------------------------
// display_scan_driver_if
//
// Bundles the value/load inputs and the decoder-facing outputs of
// display_scan_driver. CLK and RESET_N stay plain ports on the module.
//
//   VALUE_IN        [15:0]  value to display, [3:0] is digit 0 (rightmost)
//   DOTS_IN         [3:0]   decimal-point request, bit k = digit k
//   LOAD_IN                 single-cycle strobe capturing VALUE_IN/DOTS_IN
//   LZB_EN_IN               leading-zero blanking enable
//   SEG_SELECT_OUT  [1:0]   current digit index
//   BIN_OUT         [3:0]   nibble of the current digit
//   DOT_OUT                 dot flag of the current digit
//   BLANK_OUT               current digit suppressed
//   PENDING_OUT             staged value waiting for the next frame boundary
//   FRAME_OUT               one-cycle pulse as digit 0 becomes active
//
// master: drives the inputs (system side / testbench)
// slave : the scan driver itself
//------------------------------------------------------------------------------
`timescale 1ns/1ps

interface display_scan_driver_if;
  logic [15:0] VALUE_IN;
  logic [3:0]  DOTS_IN;
  logic        LOAD_IN;
  logic        LZB_EN_IN;
  logic [1:0]  SEG_SELECT_OUT;
  logic [3:0]  BIN_OUT;
  logic        DOT_OUT;
  logic        BLANK_OUT;
  logic        PENDING_OUT;
  logic        FRAME_OUT;

  modport master (
    output VALUE_IN, DOTS_IN, LOAD_IN, LZB_EN_IN,
    input  SEG_SELECT_OUT, BIN_OUT, DOT_OUT, BLANK_OUT, PENDING_OUT, FRAME_OUT
  );

  modport slave (
    input  VALUE_IN, DOTS_IN, LOAD_IN, LZB_EN_IN,
    output SEG_SELECT_OUT, BIN_OUT, DOT_OUT, BLANK_OUT, PENDING_OUT, FRAME_OUT
  );
endinterface

// File: rtl/display_scan_driver.sv
//------------------------------------------------------------------------------
// display_scan_driver
//
// Time-multiplexing scan driver for a 4-digit 7-segment display. A prescaler
// divides CLK down to one digit slot every REFRESH_DIV cycles; the digit index
// walks 0,1,2,3,0. Loads land in a staging register and are committed to the
// display register only at the frame boundary (digit 3 -> digit 0), so a
// frame never shows a mix of old and new digits. Optional leading-zero
// blanking suppresses high-order zero digits, with a set dot forcing its
// digit and all lower digits visible.
//
// Ports:
//   CLK      system clock, rising edge
//   RESET_N  asynchronous active-low reset
//   bus      display_scan_driver_if.slave (value/load in, decoder drive out)
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module display_scan_driver #(
  parameter int REFRESH_DIV = 50000,
  parameter int CNT_WIDTH   = 17
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  display_scan_driver_if.slave  bus
);

  localparam logic [CNT_WIDTH-1:0] PRESCALE_LAST = CNT_WIDTH'(REFRESH_DIV - 1);

  logic [CNT_WIDTH-1:0] prescaler_q, prescaler_d;
  logic [1:0]           digit_q, digit_d;
  logic [15:0]          stage_val_q, stage_val_d;
  logic [3:0]           stage_dots_q, stage_dots_d;
  logic [15:0]          disp_val_q, disp_val_d;
  logic [3:0]           disp_dots_q, disp_dots_d;
  logic                 pending_q, pending_d;

  logic                 tick;
  logic                 frame_start;
  logic [3:0]           nibble_d;
  logic [3:0]           blank_vec;

  assign tick        = (prescaler_q == PRESCALE_LAST);
  assign frame_start = tick && (digit_q == 2'd3);

  // Next-state for the scan position and the load handshake.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    prescaler_d  = prescaler_q + CNT_WIDTH'(1);
    digit_d      = digit_q;
    stage_val_d  = stage_val_q;
    stage_dots_d = stage_dots_q;
    disp_val_d   = disp_val_q;
    disp_dots_d  = disp_dots_q;
    pending_d    = pending_q;

    // Wrap is explicit so REFRESH_DIV need not be a power of two.
    if (tick) begin
      prescaler_d = '0;
      digit_d     = (digit_q == 2'd3) ? 2'd0 : digit_q + 2'd1;
    end

    if (frame_start && bus.LOAD_IN) begin
      // Load on the boundary itself bypasses staging and supersedes any
      // older staged value.
      disp_val_d  = bus.VALUE_IN;
      disp_dots_d = bus.DOTS_IN;
      pending_d   = 1'b0;
    end else if (frame_start && pending_q) begin
      disp_val_d  = stage_val_q;
      disp_dots_d = stage_dots_q;
      pending_d   = 1'b0;
    end else if (bus.LOAD_IN) begin
      // Last load before the boundary wins.
      stage_val_d  = bus.VALUE_IN;
      stage_dots_d = bus.DOTS_IN;
      pending_d    = 1'b1;
    end
  end

  // Output data is derived from next-state values so index and data
  // always change on the same edge.
  always_comb begin
    nibble_d = disp_val_d[3:0];
    unique case (digit_d)
      2'd0: nibble_d = disp_val_d[3:0];
      2'd1: nibble_d = disp_val_d[7:4];
      2'd2: nibble_d = disp_val_d[11:8];
      2'd3: nibble_d = disp_val_d[15:12];
    endcase

    // Zero-detect chain from the top digit down: a digit is blank only if it
    // and every digit above it are zero with no dot set among them.
    blank_vec[3] = bus.LZB_EN_IN && (disp_val_d[15:12] == 4'h0) && !disp_dots_d[3];
    blank_vec[2] = blank_vec[3]  && (disp_val_d[11:8]  == 4'h0) && !disp_dots_d[2];
    blank_vec[1] = blank_vec[2]  && (disp_val_d[7:4]   == 4'h0) && !disp_dots_d[1];
    blank_vec[0] = 1'b0;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      // NOTE: staging and display registers are reset too, so the display
      // shows 0000 after reset instead of stale or undefined data.
      prescaler_q        <= '0;
      digit_q            <= 2'd0;
      stage_val_q        <= '0;
      stage_dots_q       <= '0;
      disp_val_q         <= '0;
      disp_dots_q        <= '0;
      pending_q          <= 1'b0;
      bus.SEG_SELECT_OUT <= 2'd0;
      bus.BIN_OUT        <= 4'h0;
      bus.DOT_OUT        <= 1'b0;
      bus.BLANK_OUT      <= 1'b0;
      bus.FRAME_OUT      <= 1'b0;
    end else begin
      prescaler_q        <= prescaler_d;
      digit_q            <= digit_d;
      stage_val_q        <= stage_val_d;
      stage_dots_q       <= stage_dots_d;
      disp_val_q         <= disp_val_d;
      disp_dots_q        <= disp_dots_d;
      pending_q          <= pending_d;
      bus.SEG_SELECT_OUT <= digit_d;
      bus.BIN_OUT        <= nibble_d;
      bus.DOT_OUT        <= disp_dots_d[digit_d];
      bus.BLANK_OUT      <= blank_vec[digit_d];
      bus.FRAME_OUT      <= frame_start;
    end
  end

  assign bus.PENDING_OUT = pending_q;

endmodule

// File: tb/tb_display_scan_driver.sv
//------------------------------------------------------------------------------
// tb_display_scan_driver
//
// Scoreboard bench for display_scan_driver with REFRESH_DIV=4. A reference
// model, driven by the cycle count since reset, derives the expected outputs
// after every edge and queues them; a monitor pops one entry per cycle on the
// falling edge and compares. Directed scenarios come first, then random loads,
// values, dots, blanking toggles and occasional resets.
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_display_scan_driver;

  localparam int DIV   = 4;
  localparam int FRAME = 4 * DIV;

  typedef struct {
    logic [1:0] seg;
    logic [3:0] bin;
    logic       dot;
    logic       blank;
    logic       pending;
    logic       frame;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  display_scan_driver_if u_if ();

  display_scan_driver #(
    .REFRESH_DIV (DIV),
    .CNT_WIDTH   (3)
  ) dut (
    .CLK     (clk),
    .RESET_N (rst_n),
    .bus     (u_if.slave)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t exp_q[$];

  // Reference model state.
  int          m_cyc;        // edges since reset release
  logic [15:0] m_val;
  logic [3:0]  m_dots;
  logic [15:0] m_stage_val;
  logic [3:0]  m_stage_dots;
  bit          m_pending;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Digit d is blank when blanking is on, it is not digit 0, and every digit
  // from d upward is zero with no dot requested.
  function automatic logic exp_blank(input int d, input logic lzb,
                                     input logic [15:0] v, input logic [3:0] dots);
    if (!lzb || d == 0) return 1'b0;
    for (int j = d; j < 4; j++) begin
      if (((v >> (4 * j)) & 16'h000F) != 16'h0000 || dots[j]) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Reference model: one expectation per edge, or a reset expectation.
  initial begin
    exp_t e;
    bit   fs;
    int   dig;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_cyc        = 0;
        m_val        = '0;
        m_dots       = '0;
        m_stage_val  = '0;
        m_stage_dots = '0;
        m_pending    = 1'b0;
        exp_q.delete();
        e = '{default: '0};
        exp_q.push_back(e);
      end else begin
        // The edge closing the last cycle of each 4*DIV-cycle frame is the
        // frame boundary.
        fs = ((m_cyc % FRAME) == FRAME - 1);
        if (fs && u_if.LOAD_IN) begin
          m_val     = u_if.VALUE_IN;
          m_dots    = u_if.DOTS_IN;
          m_pending = 1'b0;
        end else if (fs && m_pending) begin
          m_val     = m_stage_val;
          m_dots    = m_stage_dots;
          m_pending = 1'b0;
        end else if (u_if.LOAD_IN) begin
          m_stage_val  = u_if.VALUE_IN;
          m_stage_dots = u_if.DOTS_IN;
          m_pending    = 1'b1;
        end
        m_cyc++;
        dig       = (m_cyc / DIV) % 4;
        e.seg     = 2'(dig);
        e.bin     = 4'(m_val >> (4 * dig));
        e.dot     = m_dots[dig];
        e.blank   = exp_blank(dig, u_if.LZB_EN_IN, m_val, m_dots);
        e.pending = m_pending;
        e.frame   = fs;
        exp_q.push_back(e);
      end
    end
  end

  // Monitor: samples mid-cycle, away from the active edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("seg_select", 16'(u_if.SEG_SELECT_OUT), 16'(e.seg));
        check("bin",        16'(u_if.BIN_OUT),        16'(e.bin));
        check("dot",        16'(u_if.DOT_OUT),        16'(e.dot));
        check("blank",      16'(u_if.BLANK_OUT),      16'(e.blank));
        check("pending",    16'(u_if.PENDING_OUT),    16'(e.pending));
        check("frame",      16'(u_if.FRAME_OUT),      16'(e.frame));
      end
    end
  end

  // Inputs change 2 time units after the rising edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    u_if.VALUE_IN = v;
    u_if.DOTS_IN  = d;
    u_if.LOAD_IN  = 1'b1;
    step(1);
    u_if.LOAD_IN  = 1'b0;
    u_if.VALUE_IN = 16'($urandom);
    u_if.DOTS_IN  = 4'($urandom);
  endtask

  // Returns with the next rising edge being a frame boundary.
  task automatic wait_frame_edge();
    int guard;
    guard = 0;
    while ((m_cyc % FRAME) != FRAME - 1 && guard < 2 * FRAME) begin
      step(1);
      guard++;
    end
    if (guard >= 2 * FRAME) begin
      n_checks++;
      n_errors++;
      $display("FAIL frame_align: boundary not reached within %0d cycles", 2 * FRAME);
    end
  endtask

  initial begin
    logic [15:0] mask;
    int          guard;
    u_if.VALUE_IN  = '0;
    u_if.DOTS_IN   = '0;
    u_if.LOAD_IN   = 1'b0;
    u_if.LZB_EN_IN = 1'b0;

    // Reset and free-running scan of the reset value.
    step(3);
    rst_n = 1'b1;
    step(40);

    // Mid-frame load.
    step(5);
    do_load(16'h1A2F, 4'b0100);
    step(40);

    // Two loads in one frame: only the second is ever shown.
    wait_frame_edge();
    step(2);
    do_load(16'h1111, 4'b0000);
    step(3);
    do_load(16'h2222, 4'b0000);
    step(40);

    // Load on the exact boundary, with and without blanking.
    u_if.LZB_EN_IN = 1'b1;
    wait_frame_edge();
    do_load(16'h00F0, 4'b0000);
    step(20);
    u_if.LZB_EN_IN = 1'b0;
    wait_frame_edge();
    do_load(16'h00F0, 4'b0000);
    step(20);

    // Leading-zero blanking and dot override.
    u_if.LZB_EN_IN = 1'b1;
    do_load(16'h0007, 4'b0000);
    step(40);
    do_load(16'h0000, 4'b0100);
    step(40);
    u_if.LZB_EN_IN = 1'b0;
    step(20);

    // Asynchronous reset in the middle of digit 2 with a load pending.
    u_if.LZB_EN_IN = 1'b1;
    wait_frame_edge();
    step(2);
    do_load(16'hBEEF, 4'b0001);
    guard = 0;
    while (!(((m_cyc / DIV) % 4) == 2 && (m_cyc % DIV) == 1) && guard < 2 * FRAME) begin
      step(1);
      guard++;
    end
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(40);

    // Randomised traffic.
    for (int i = 0; i < 1500; i++) begin
      case ($urandom_range(0, 3))
        0:       mask = 16'hFFFF;
        1:       mask = 16'h00FF;
        2:       mask = 16'h000F;
        default: mask = 16'h0000;
      endcase
      u_if.VALUE_IN = 16'($urandom) & mask;
      u_if.DOTS_IN  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      u_if.LOAD_IN  = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 19) == 0) u_if.LZB_EN_IN = ~u_if.LZB_EN_IN;
      if ($urandom_range(0, 399) == 0) begin
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
      end
      step(1);
    end
    u_if.LOAD_IN = 1'b0;
    step(4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/display_scan_driver.md
Name: display_scan_driver

Overview:
Time-multiplexing scan driver for the 4-digit 7-segment display, sitting directly upstream of the segment decoder. It holds a 16-bit display value as four hex nibbles plus four decimal-point flags, and steps through the digits at a programmable refresh rate. For each digit it presents the digit index, nibble and dot to the decoder. Value updates are double-buffered and committed only at frame boundaries, and leading-zero blanking is optional.

Parameters:
REFRESH_DIV, 50000, CLK cycles per digit slot (50 MHz gives a 1 kHz digit rate, 250 Hz frame rate); legal range 2 to 2^CNT_WIDTH.
CNT_WIDTH, 17, prescaler counter width.

Ports:
CLK  input  1  system clock; all state on rising edge
RESET_N  input  1  asynchronous, active-low reset
VALUE_IN  input  16  value to display; [3:0] is digit 0 (rightmost) ... [15:12] is digit 3
DOTS_IN  input  4  decimal-point request per digit, bit k = digit k, active-high
LOAD_IN  input  1  single-cycle strobe; captures VALUE_IN/DOTS_IN into the staging register
LZB_EN_IN  input  1  leading-zero blanking enable
SEG_SELECT_OUT  output  2  current digit index, to the decoder segment-select input
BIN_OUT  output  4  nibble of the current digit, to the decoder binary input
DOT_OUT  output  1  dot flag of the current digit, active-high, to the decoder dot input
BLANK_OUT  output  1  current digit suppressed; top level forces all anodes off while high
PENDING_OUT  output  1  staged value is waiting for the next frame boundary
FRAME_OUT  output  1  one-cycle pulse, coincident with the edge where digit 0 becomes active

Behaviour:
- Reset (async assert, sync-safe deassert): prescaler=0, digit=0, staging=0, display register=0; every output=0.
- Prescaler: counts 0..REFRESH_DIV-1, then wraps to 0. tick = (prescaler==REFRESH_DIV-1).
- Digit counter advances on tick: 0->1->2->3->0. Each digit is held exactly REFRESH_DIV cycles.
- frame_start = tick AND digit==3.
- All outputs are registered. SEG_SELECT_OUT, BIN_OUT, DOT_OUT and BLANK_OUT are computed from next-state values, so all four change on the same edge. No cycle exists where the index and the data disagree.
- BIN_OUT = display[4k+3:4k] and DOT_OUT = display_dots[k], where k is the new digit index.
- Load handshake:
  - LOAD_IN=1 captures VALUE_IN/DOTS_IN into staging and sets pending.
  - On frame_start with pending=1, staging is copied to the display register and pending clears.
  - The committed value is first visible on digit 0 in the same edge as FRAME_OUT.
  - Repeated LOAD_IN while pending: last one wins; the earlier staged value is discarded.
  - LOAD_IN coincident with frame_start: the new VALUE_IN/DOTS_IN goes straight to the display register, pending stays 0, and PENDING_OUT never asserts.
  - PENDING_OUT = pending register, high from the cycle after LOAD_IN through the commit edge (low after it).
- Without LOAD_IN, the display register holds indefinitely.
- Leading-zero blanking, evaluated on the display register:
  - Digit k in 1..3 is blanked iff LZB_EN_IN=1 and nibbles 3 down to k are all zero.
  - Digit 0 is never blanked, so value 0 shows a single "0".
  - A set dot on a digit un-blanks that digit and all digits below it.
  - LZB_EN_IN is sampled each cycle; no frame alignment is required for it.
- FRAME_OUT is high for exactly one cycle per 4*REFRESH_DIV cycles.
- Reset mid-frame: immediate return to the reset state. A pending load is lost, and scanning restarts at digit 0 with a fresh prescaler.
- Combinational depth: one 4:1 nibble mux plus the zero-detect chain. No arithmetic beyond the prescaler increment, whose wrap is explicit (no reliance on overflow).

Test Plan:
- Reset, then release with REFRESH_DIV=4: SEG_SELECT_OUT steps 0,1,2,3,0 every 4 cycles; FRAME_OUT pulses every 16 cycles; all other outputs 0.
- LOAD_IN with VALUE_IN=16'h1A2F, DOTS_IN=4'b0100 mid-frame: PENDING_OUT=1 until the next frame_start. From the commit edge, BIN_OUT sequence is F,2,A,1 with DOT_OUT=1 only while SEG_SELECT_OUT=2; PENDING_OUT then 0.
- Two LOAD_IN strobes in one frame (16'h1111 then 16'h2222): only 2,2,2,2 is ever displayed; 1111 never appears.
- LOAD_IN of 16'h00F0 on the exact frame_start cycle: the digit-0 slot in that edge shows 0 with no PENDING_OUT pulse, then F, 0 (blanked iff LZB on), 0.
- LZB_EN_IN=1 with value 16'h0007: BLANK_OUT=1 on digits 3,2,1 and 0 on digit 0. With value 16'h0000 and DOTS_IN=4'b0100: digits 2,1,0 unblanked and digit 3 blanked. With LZB_EN_IN=0: BLANK_OUT is never high.
- RESET_N asserted asynchronously mid-digit-2 with a load pending: outputs go to 0 immediately, PENDING_OUT=0. After release, the display shows 0000 and scanning restarts at digit 0.
